// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between a byte producer and uart_frame_transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 send;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic                 tx_o;

    modport master (
        output data,
        output send,
        input  ready,
        input  busy,
        input  done,
        input  tx_o
    );

    modport slave (
        input  data,
        input  send,
        output ready,
        output busy,
        output done,
        output tx_o
    );
endinterface

// File: rtl/uart_frame_transmitter.sv
// Self-timed UART transmitter: internal baud counter, one-deep holding register,
// optional parity and one or two stop bits. Frames chain with no idle gap.
module uart_frame_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic      clk,
    input logic      reset,
    uart_tx_if.slave bus
);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_BITS - 1);
    localparam logic             StopLast = (STOP_BITS == 2);
    localparam logic             ParEn    = (PARITY_EN != 0);
    localparam logic             ParOdd   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        sIdle,
        sStart,
        sData,
        sParity,
        sStop
    } state_e;

    state_e               state_q, state_d;
    logic [BaudW-1:0]     baud_q, baud_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic bit_end;
    logic load;
    logic accept;

    assign bit_end = (baud_q == BaudLast);
    assign accept  = bus.send && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            sIdle: begin
                load = hold_full_q;
            end
            sStart: begin
                if (bit_end) begin
                    state_d = sData;
                    baud_d  = '0;
                    idx_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            sData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxLast) begin
                        state_d = ParEn ? sParity : sStop;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            sParity: begin
                if (bit_end) begin
                    state_d = sStop;
                    baud_d  = '0;
                    stop_d  = 1'b0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            sStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (stop_q == StopLast) begin
                        done_d  = 1'b1;
                        state_d = sIdle;
                        // A queued byte starts straight after the stop bit, no idle gap.
                        load    = hold_full_q;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = sIdle;
            end
        endcase

        if (load) begin
            state_d     = sStart;
            baud_d      = '0;
            shift_d     = hold_q;
            parity_d    = (^hold_q) ^ ParOdd;
            hold_full_d = 1'b0;
        end

        // load needs a full holding register, accept an empty one: never both.
        if (accept) begin
            hold_d      = bus.data;
            hold_full_d = 1'b1;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            sIdle:   tx_d = 1'b1;
            sStart:  tx_d = 1'b0;
            sData:   tx_d = shift_d[0];
            sParity: tx_d = parity_d;
            sStop:   tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != sIdle) || hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= sIdle;
            baud_q      <= '0;
            idx_q       <= '0;
            stop_q      <= 1'b0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.ready = !hold_full_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tx_o  = tx_q;
endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Bench for uart_frame_transmitter: three configurations (8N1, 8E1, 8O2) checked
// every cycle against a frame-pattern model, plus literal frame captures.
module tb_uart_frame_transmitter;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       send_r [3];
    logic [7:0] data_r [3];
    logic       tx_w   [3];
    logic       rdy_w  [3];
    logic       busy_w [3];
    logic       done_w [3];

    int pen  [3] = '{0, 1, 1};
    int podd [3] = '{0, 0, 1};
    int nst  [3] = '{1, 1, 2};

    uart_tx_if #(.DATA_BITS(8)) u0 ();
    uart_tx_if #(.DATA_BITS(8)) u1 ();
    uart_tx_if #(.DATA_BITS(8)) u2 ();

    assign u0.send = send_r[0];
    assign u1.send = send_r[1];
    assign u2.send = send_r[2];
    assign u0.data = data_r[0];
    assign u1.data = data_r[1];
    assign u2.data = data_r[2];
    assign tx_w[0] = u0.tx_o;
    assign tx_w[1] = u1.tx_o;
    assign tx_w[2] = u2.tx_o;
    assign rdy_w[0] = u0.ready;
    assign rdy_w[1] = u1.ready;
    assign rdy_w[2] = u2.ready;
    assign busy_w[0] = u0.busy;
    assign busy_w[1] = u1.busy;
    assign busy_w[2] = u2.busy;
    assign done_w[0] = u0.done;
    assign done_w[1] = u1.done;
    assign done_w[2] = u2.done;

    uart_frame_transmitter #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut0 (.clk(clk), .reset(reset), .bus(u0));

    uart_frame_transmitter #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut1 (.clk(clk), .reset(reset), .bus(u1));

    uart_frame_transmitter #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dut2 (.clk(clk), .reset(reset), .bus(u2));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic checking = 1'b0;

    int done_cnt [3] = '{0, 0, 0};
    int done_cyc [3] = '{0, 0, 0};
    int run      [3] = '{0, 0, 0};
    int last_run [3] = '{0, 0, 0};

    task automatic chk(input string name, input int ch, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s ch%0d at cycle %0d: got %0h expected %0h", name, ch, cyc, act, exp);
        end
    endtask

    // Line levels of a whole frame, one entry per bit, start bit first.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int ch);
        logic [15:0] b;
        int n;
        b = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            b[n] = d[i];
            n++;
        end
        if (pen[ch] != 0) begin
            b[n] = (^d) ^ (podd[ch] != 0);
            n++;
        end
        for (int s = 0; s < nst[ch]; s++) begin
            b[n] = 1'b1;
            n++;
        end
        return b;
    endfunction

    function automatic int frame_nbits(input int ch);
        return 1 + 8 + pen[ch] + nst[ch];
    endfunction

    // Model: a holding slot plus the frame currently on the line, indexed by elapsed cycles.
    logic        m_active [3];
    logic        m_hold_v [3];
    logic [7:0]  m_hold   [3];
    logic [15:0] m_bits   [3];
    int          m_cyc    [3];
    int          m_len    [3];
    logic        m_done   [3];

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        logic acc;
        for (int ch = 0; ch < 3; ch++) begin
            if (reset) begin
                m_active[ch] = 1'b0;
                m_hold_v[ch] = 1'b0;
                m_done[ch]   = 1'b0;
                m_cyc[ch]    = 0;
                m_len[ch]    = 0;
            end else begin
                acc = send_r[ch] && !m_hold_v[ch];
                m_done[ch] = 1'b0;
                if (m_active[ch]) begin
                    m_cyc[ch]++;
                    if (m_cyc[ch] == m_len[ch]) begin
                        m_active[ch] = 1'b0;
                        m_done[ch]   = 1'b1;
                    end
                end
                if (!m_active[ch] && m_hold_v[ch]) begin
                    m_bits[ch]   = frame_bits(m_hold[ch], ch);
                    m_len[ch]    = frame_nbits(ch) * CPB;
                    m_cyc[ch]    = 0;
                    m_active[ch] = 1'b1;
                    m_hold_v[ch] = 1'b0;
                end
                if (acc) begin
                    m_hold_v[ch] = 1'b1;
                    m_hold[ch]   = data_r[ch];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int ch = 0; ch < 3; ch++) begin
                chk("tx_o", ch, int'(tx_w[ch]),
                    int'(m_active[ch] ? m_bits[ch][m_cyc[ch] / CPB] : 1'b1));
                chk("ready", ch, int'(rdy_w[ch]), int'(!m_hold_v[ch]));
                chk("busy", ch, int'(busy_w[ch]), int'(m_active[ch] || m_hold_v[ch]));
                chk("done", ch, int'(done_w[ch]), int'(m_done[ch]));
                if (done_w[ch] === 1'b1) begin
                    done_cnt[ch]++;
                    done_cyc[ch] = cyc;
                end
                if (busy_w[ch] === 1'b1) begin
                    run[ch]++;
                end else if (run[ch] > 0) begin
                    last_run[ch] = run[ch];
                    run[ch] = 0;
                end
            end
        end
    end

    task automatic send_byte(input int ch, input logic [7:0] v);
        @(posedge clk);
        #1;
        data_r[ch] = v;
        send_r[ch] = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        send_r[ch] = 1'b0;
    endtask

    task automatic capture(input int ch, input int nbits, output logic [15:0] v, output int len);
        int c;
        v = '0;
        len = 0;
        c = 0;
        while (tx_w[ch] !== 1'b0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) begin
            chk("start_timeout", ch, c, 0);
            return;
        end
        c = 0;
        for (int i = 0; i < nbits; i++) begin
            while (c < i * CPB + 2) begin
                @(negedge clk);
                c++;
            end
            v[i] = tx_w[ch];
        end
        while (done_w[ch] !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) chk("done_timeout", ch, c, 0);
        len = c;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int ch);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy_w[ch] !== 1'b0 && t < 300);
        if (t >= 300) chk("idle_timeout", ch, t, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] v;
        int len;
        int dc;
        for (int ch = 0; ch < 3; ch++) begin
            send_r[ch] = 1'b0;
            data_r[ch] = 8'h00;
        end

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checking = 1'b1;

        // Idle: 20 cycles with no request.
        repeat (20) @(negedge clk);
        chk("idle_tx", 0, int'(tx_w[0]), 1);
        chk("idle_ready", 0, int'(rdy_w[0]), 1);
        chk("idle_busy", 0, int'(busy_w[0]), 0);
        chk("idle_done_cnt", 0, done_cnt[0], 0);

        // 8N1 frame of 0xA5.
        send_byte(0, 8'hA5);
        capture(0, 10, v, len);
        chk("frame_a5", 0, int'(v), 16'h34A);
        chk("len_a5", 0, len, 40);
        chk("latency_a5", 0, done_cyc[0] - acc_cyc, 41);
        wait_idle(0);

        // Back-to-back with a dropped third request.
        dc = done_cnt[0];
        send_byte(0, 8'h55);
        repeat (10) @(posedge clk);
        send_byte(0, 8'h0F);
        repeat (3) @(posedge clk);
        send_byte(0, 8'hFF);
        wait_idle(0);
        chk("b2b_done_cnt", 0, done_cnt[0] - dc, 2);
        chk("b2b_busy_run", 0, last_run[0], 81);

        // Even parity, one stop.
        send_byte(1, 8'h07);
        capture(1, 11, v, len);
        chk("frame_07_even", 1, int'(v), 16'h60E);
        chk("len_even", 1, len, 44);
        wait_idle(1);

        // Odd parity, two stops.
        send_byte(2, 8'h07);
        capture(2, 12, v, len);
        chk("frame_07_odd2", 2, int'(v), 16'hC0E);
        chk("len_odd2", 2, len, 48);
        wait_idle(2);

        // Reset during data bit 3 of 0xC3.
        dc = done_cnt[0];
        send_byte(0, 8'hC3);
        repeat (17) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx", 0, int'(tx_w[0]), 1);
        chk("rst_busy", 0, int'(busy_w[0]), 0);
        chk("rst_ready", 0, int'(rdy_w[0]), 1);
        repeat (50) @(negedge clk);
        chk("rst_no_done", 0, done_cnt[0] - dc, 0);
        send_byte(0, 8'h3C);
        capture(0, 10, v, len);
        chk("frame_3c", 0, int'(v), 16'h278);
        wait_idle(0);

        // Data changes right after acceptance.
        send_byte(1, 8'h81);
        data_r[1] = 8'hFF;
        capture(1, 11, v, len);
        chk("frame_81", 1, int'(v), 16'h502);
        wait_idle(1);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
